// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
//   hz_state_e  : memory-wait FSM states (RUN = normal flow, WAIT = frozen on data memory)
//   NOP_INSTR   : encoding of the bubble instruction (addi x0,x0,0) loaded on flush/bubble
//   PRIO_*      : relative priority of the three hazard sources (higher wins)
package hazard_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } hz_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  localparam int PRIO_FREEZE   = 2;
  localparam int PRIO_BRANCH   = 1;
  localparam int PRIO_LOAD_USE = 0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk    : rising-edge clock
//   clr_n  : synchronous clear, active low
//   en     : count this cycle
//   count  : current value, sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage RV32 pipeline.
// Resolves what forwarding cannot: load-use (one bubble), taken branches
// (flush IF/ID + ID/EX) and multi-cycle data-memory accesses (full freeze).
//   clk, rst_n                 : clock, synchronous active-low reset
//   IFID_rs1/rs2/uses_rs2      : source registers of the instruction in ID
//   IDEX_rd/IDEX_MemRead       : destination / load flag of the instruction in EX
//   branch_taken               : EX resolved a taken branch/jump
//   dmem_req/dmem_ready        : data-memory handshake from MEM
//   PC_write, IFID_write       : enables for PC and IF/ID
//   IFID_flush, IDEX_bubble    : NOP insertion into IF/ID and ID/EX
//   pipe_freeze                : hold ID/EX, EX/MEM, MEM/WB
//   stall_cnt, flush_cnt       : saturating event counters
//   mem_timeout                : sticky, a request waited MEM_TIMEOUT frozen cycles
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64,
  parameter int TO_W        = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IFID_rs1,
  input  logic [4:0]       IFID_rs2,
  input  logic             IFID_uses_rs2,
  input  logic [4:0]       IDEX_rd,
  input  logic             IDEX_MemRead,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             PC_write,
  output logic             IFID_write,
  output logic             IFID_flush,
  output logic             IDEX_bubble,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  hz_state_e       state_reg, state_next;
  logic [TO_W-1:0] wait_cnt_reg;
  logic            timeout_reg;
  logic            lu, frz;
  logic            stall_en, flush_en;

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign lu = IDEX_MemRead && (IDEX_rd != 5'd0) &&
              ((IDEX_rd == IFID_rs1) || (IFID_uses_rs2 && (IDEX_rd == IFID_rs2)));

  // In WAIT the request is already outstanding, so dmem_req is not re-checked.
  assign frz = (state_reg == RUN)  ? (dmem_req && !dmem_ready)
                                   : !dmem_ready;

  // Priority: freeze > branch flush > load-use. Outputs stay at the
  // free-running values while reset is held.
  always_comb begin
    PC_write    = 1'b1;
    IFID_write  = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_bubble = 1'b0;
    pipe_freeze = 1'b0;
    state_next  = state_reg;
    if (rst_n) begin
      if (frz) begin
        PC_write    = 1'b0;
        IFID_write  = 1'b0;
        pipe_freeze = 1'b1;
      end else if (branch_taken) begin
        IFID_flush  = 1'b1;
        IDEX_bubble = 1'b1;
      end else if (lu) begin
        PC_write    = 1'b0;
        IFID_write  = 1'b0;
        IDEX_bubble = 1'b1;
      end
      state_next = frz ? WAIT : RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= RUN;
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (!frz) begin
        wait_cnt_reg <= '0;
      end else if (state_reg == RUN) begin
        wait_cnt_reg <= TO_W'(1);
      end else if (wait_cnt_reg != TO_W'(MEM_TIMEOUT)) begin
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
      end
      // Flag only; the FSM keeps waiting for the memory.
      if ((state_reg == WAIT) && !dmem_ready &&
          (wait_cnt_reg == TO_W'(MEM_TIMEOUT - 1))) begin
        timeout_reg <= 1'b1;
      end
    end
  end

  assign mem_timeout = timeout_reg;

  // A branch squashes the load-use consumer, so that cycle is not a stall.
  assign stall_en = frz || (lu && !branch_taken);
  assign flush_en = !frz && branch_taken;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .en    (stall_en),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .en    (flush_en),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

  localparam int CNT_W       = 2;
  localparam int MEM_TIMEOUT = 4;
  localparam int TO_W        = 3;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       IFID_rs1, IFID_rs2, IDEX_rd;
  logic             IFID_uses_rs2, IDEX_MemRead, branch_taken, dmem_req, dmem_ready;
  logic             PC_write, IFID_write, IFID_flush, IDEX_bubble, pipe_freeze, mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_stall_unit #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .IFID_rs1      (IFID_rs1),
    .IFID_rs2      (IFID_rs2),
    .IFID_uses_rs2 (IFID_uses_rs2),
    .IDEX_rd       (IDEX_rd),
    .IDEX_MemRead  (IDEX_MemRead),
    .branch_taken  (branch_taken),
    .dmem_req      (dmem_req),
    .dmem_ready    (dmem_ready),
    .PC_write      (PC_write),
    .IFID_write    (IFID_write),
    .IFID_flush    (IFID_flush),
    .IDEX_bubble   (IDEX_bubble),
    .pipe_freeze   (pipe_freeze),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt),
    .mem_timeout   (mem_timeout)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: "is a memory request outstanding", how many frozen
  // cycles it has accumulated, and plain integer event totals clipped at max.
  bit primed = 0;
  bit m_waiting = 0, n_waiting;
  int m_waited = 0, n_waited;
  int m_stalls = 0, n_stalls;
  int m_flushes = 0, n_flushes;
  bit m_to = 0, n_to;

  always @(negedge clk) begin
    bit dep, frz, stall_ev;
    bit e_pc, e_ifid, e_flush, e_bub, e_frz;
    if (primed) begin
      dep = IDEX_MemRead && IDEX_rd != 0 &&
            (IDEX_rd == IFID_rs1 || (IFID_uses_rs2 && IDEX_rd == IFID_rs2));
      frz = m_waiting ? !dmem_ready : (dmem_req && !dmem_ready);
      e_pc = 1; e_ifid = 1; e_flush = 0; e_bub = 0; e_frz = 0;
      if (rst_n) begin
        if (frz) begin
          e_pc = 0; e_ifid = 0; e_frz = 1;
        end else if (branch_taken) begin
          e_flush = 1; e_bub = 1;
        end else if (dep) begin
          e_pc = 0; e_ifid = 0; e_bub = 1;
        end
      end
      chk("PC_write",    int'(PC_write),    int'(e_pc));
      chk("IFID_write",  int'(IFID_write),  int'(e_ifid));
      chk("IFID_flush",  int'(IFID_flush),  int'(e_flush));
      chk("IDEX_bubble", int'(IDEX_bubble), int'(e_bub));
      chk("pipe_freeze", int'(pipe_freeze), int'(e_frz));
      chk("stall_cnt",   int'(stall_cnt),   m_stalls);
      chk("flush_cnt",   int'(flush_cnt),   m_flushes);
      chk("mem_timeout", int'(mem_timeout), int'(m_to));
      stall_ev  = frz || (dep && !branch_taken);
      n_waiting = frz;
      n_waited  = frz ? m_waited + 1 : 0;
      n_to      = m_to || (frz && n_waited >= MEM_TIMEOUT);
      n_stalls  = (stall_ev && m_stalls < CNT_MAX) ? m_stalls + 1 : m_stalls;
      n_flushes = (!frz && branch_taken && m_flushes < CNT_MAX) ? m_flushes + 1 : m_flushes;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      primed <= 1; m_waiting <= 0; m_waited <= 0;
      m_stalls <= 0; m_flushes <= 0; m_to <= 0;
    end else if (primed) begin
      m_waiting <= n_waiting; m_waited <= n_waited;
      m_stalls <= n_stalls; m_flushes <= n_flushes; m_to <= n_to;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    IFID_rs1 = 0; IFID_rs2 = 0; IFID_uses_rs2 = 0; IDEX_rd = 0;
    IDEX_MemRead = 0; branch_taken = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_in();
    cyc();
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    clear_in();
    cyc(); cyc();
    rst_n = 1;
    #1;
    chk("rst_pc", int'(PC_write), 1);
    chk("rst_freeze", int'(pipe_freeze), 0);
    chk("rst_stall", int'(stall_cnt), 0);
    chk("rst_flush", int'(flush_cnt), 0);
    chk("rst_timeout", int'(mem_timeout), 0);

    // load-use on rs1
    IDEX_MemRead = 1; IDEX_rd = 5; IFID_rs1 = 5; #1;
    chk("lu_pc", int'(PC_write), 0);
    chk("lu_ifid", int'(IFID_write), 0);
    chk("lu_bubble", int'(IDEX_bubble), 1);
    cyc();
    clear_in(); #1;
    chk("lu_stall_cnt", int'(stall_cnt), 1);

    // rs2 not read, and x0 destination: no stall
    IDEX_MemRead = 1; IDEX_rd = 7; IFID_rs2 = 7; IFID_uses_rs2 = 0; IFID_rs1 = 1; #1;
    chk("rs2_unused_bubble", int'(IDEX_bubble), 0);
    IDEX_rd = 0; IFID_rs1 = 0; #1;
    chk("x0_bubble", int'(IDEX_bubble), 0);
    chk("x0_pc", int'(PC_write), 1);
    cyc();

    // branch beats load-use
    IDEX_MemRead = 1; IDEX_rd = 5; IFID_rs1 = 5; branch_taken = 1; #1;
    chk("br_flush", int'(IFID_flush), 1);
    chk("br_bubble", int'(IDEX_bubble), 1);
    chk("br_pc", int'(PC_write), 1);
    cyc();
    clear_in(); #1;
    chk("br_flush_cnt", int'(flush_cnt), 1);
    chk("br_stall_cnt", int'(stall_cnt), 1);

    // 3-cycle memory wait, branch ignored while frozen
    do_reset();
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wait_freeze", int'(pipe_freeze), 1);
      if (i == 1) begin
        branch_taken = 1; #1;
        chk("wait_br_flush", int'(IFID_flush), 0);
        chk("wait_br_pc", int'(PC_write), 0);
      end
      cyc();
      branch_taken = 0;
    end
    dmem_ready = 1; #1;
    chk("ready_freeze", int'(pipe_freeze), 0);
    cyc();
    clear_in(); #1;
    chk("wait_stall_cnt", int'(stall_cnt), 3);
    chk("wait_flush_cnt", int'(flush_cnt), 0);

    // timeout: rises after the 4th frozen cycle, sticky until reset
    do_reset();
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("timeout_rise", int'(mem_timeout), (i >= 3) ? 1 : 0);
    end
    dmem_ready = 1;
    cyc();
    clear_in(); #1;
    chk("timeout_sticky", int'(mem_timeout), 1);
    do_reset(); #1;
    chk("timeout_cleared", int'(mem_timeout), 0);

    // reset while waiting, then stall saturation
    do_reset();
    dmem_req = 1; dmem_ready = 0;
    cyc(); cyc();
    dmem_req = 0; rst_n = 0; #1;
    chk("rstwait_forced", int'(pipe_freeze), 0);
    cyc();
    rst_n = 1; #1;
    chk("rstwait_freeze", int'(pipe_freeze), 0);
    chk("rstwait_stall", int'(stall_cnt), 0);
    IDEX_MemRead = 1; IDEX_rd = 5; IFID_rs1 = 5;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("sat_stall", int'(stall_cnt), (i + 1 > 3) ? 3 : i + 1);
    end
    clear_in();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc();
      rst_n         = ($urandom_range(0, 59) != 0);
      IFID_rs1      = 5'($urandom_range(0, 3));
      IFID_rs2      = 5'($urandom_range(0, 3));
      IDEX_rd       = 5'($urandom_range(0, 3));
      IFID_uses_rs2 = 1'($urandom_range(0, 1));
      IDEX_MemRead  = 1'($urandom_range(0, 1));
      branch_taken  = ($urandom_range(0, 3) == 0);
      dmem_req      = ($urandom_range(0, 2) == 0);
      dmem_ready    = ($urandom_range(0, 9) < 3);
    end
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
